// File: rtl/pwm_mem_write_if.sv
// pwm_mem_write_if: dual-port coefficient BRAM read bus plus 64-bit output stream (Wm_tlast only with PWM_WR_TLAST_EN)
interface pwm_mem_write_if #(parameter int CW = 23);
  logic          coef_ena;
  logic [7:0]    coef_addra;
  logic [CW-1:0] coef_douta;
  logic          coef_enb;
  logic [7:0]    coef_addrb;
  logic [CW-1:0] coef_doutb;
  logic          Wm_tvalid;
  logic          Wm_tready;
  logic [63:0]   Wm_tdata;
`ifdef PWM_WR_TLAST_EN
  logic          Wm_tlast;
`endif
  modport master (
    output coef_ena, coef_addra, coef_enb, coef_addrb, Wm_tvalid, Wm_tdata,
`ifdef PWM_WR_TLAST_EN
    output Wm_tlast,
`endif
    input coef_douta, coef_doutb, Wm_tready
  );
  modport slave (
    input coef_ena, coef_addra, coef_enb, coef_addrb, Wm_tvalid, Wm_tdata,
`ifdef PWM_WR_TLAST_EN
    input Wm_tlast,
`endif
    output coef_douta, coef_doutb, Wm_tready
  );
endinterface

// File: rtl/pwm_mem_write.sv
// pwm_mem_write: drains NCOEF coefficients from dual-port BRAM into a 64-bit stream, two per word; Wm_tlast with PWM_WR_TLAST_EN
module pwm_mem_write #(
  parameter int NCOEF = 256,
  parameter int CW    = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic module_start,
  output logic module_done,
  pwm_mem_write_if.master bus
);
  localparam int NW  = NCOEF / 2;
  localparam int WCW = $clog2(NW);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0]     rd_ptr;
  logic [WCW-1:0] wr_cnt;
  logic           inflight, wp, rp, pop, issue, last_hs, start;
  logic [1:0]     occ;
  logic [63:0]    fifo [2];
  assign start   = state == IDLE && module_start;
  assign pop     = bus.Wm_tvalid & bus.Wm_tready;
  assign last_hs = pop && wr_cnt == WCW'(NW - 1);
  // credit: buffered + returning words, minus the one leaving now, must leave room for one more
  assign issue   = state == RUN && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign bus.coef_ena   = issue;
  assign bus.coef_enb   = issue;
  assign bus.coef_addra = issue ? rd_ptr : '0;
  assign bus.coef_addrb = issue ? rd_ptr + 8'd1 : '0;
  assign bus.Wm_tvalid  = occ != 2'd0;
  assign bus.Wm_tdata   = fifo[rp];
`ifdef PWM_WR_TLAST_EN
  assign bus.Wm_tlast   = bus.Wm_tvalid && wr_cnt == WCW'(NW - 1);
`endif
  always_comb begin
    state_nx = state == IDLE ? (module_start ? RUN : IDLE)
             : state == RUN  ? ((issue && rd_ptr == 8'(NCOEF - 2)) ? DRAIN : RUN)
             : (last_hs ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_cnt      <= '0;
      inflight    <= 1'b0;
      occ         <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      module_done <= 1'b0;
    end else begin
      state       <= state_nx;
      inflight    <= issue;
      module_done <= last_hs;
      occ         <= occ + {1'b0, inflight} - {1'b0, pop};
      if (start) rd_ptr <= '0;
      else if (issue) rd_ptr <= rd_ptr + 8'd2;
      if (start) wr_cnt <= '0;
      else if (pop) wr_cnt <= wr_cnt + 1'b1;
      if (inflight) begin
        fifo[wp] <= {{(32-CW){1'b0}}, bus.coef_doutb, {(32-CW){1'b0}}, bus.coef_douta};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
    end
  end
endmodule

// File: doc/pwm_mem_write.md
# pwm_mem_write

Drains one 256-coefficient polynomial from the point-wise-multiplier coefficient BRAM into the 64-bit output stream toward the DMA/FIFO, two coefficients per word. It is the write-back counterpart of the PWM load path. The BRAM is read through two ports in parallel, and each coefficient pair is packed into one stream word. Full backpressure is supported without dropping or duplicating data.

## Interface
Parameters
- `NCOEF`, 256: coefficients per polynomial; must be even; 128 words at the default.
- `CW`, 23: coefficient width (Dilithium q < 2^23).

Ports
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `module_start` in 1: one-cycle pulse that starts a transfer; ignored unless the block is IDLE.
- `coef_ena` out 1: port-A read enable.
- `coef_addra` out 8: port-A address, always even.
- `coef_douta` in CW: port-A read data, valid exactly 1 cycle after `coef_ena`.
- `coef_enb` out 1: port-B read enable, always equal to `coef_ena`.
- `coef_addrb` out 8: port-B address, equal to `coef_addra + 1`.
- `coef_doutb` in CW: port-B read data, same latency as port A.
- `Wm_tvalid` out 1: output word valid.
- `Wm_tready` in 1: downstream accepts the word.
- `Wm_tdata` out 64: packed word `{9'b0, coef[2k+1], 9'b0, coef[2k]}`; coef[2k] in bits [22:0], coef[2k+1] in bits [54:32].
- `Wm_tlast` out 1: marks the final word. Only present when `PWM_WR_TLAST_EN` is defined.
- `module_done` out 1: one-cycle completion pulse.

## Operation
- **States and transitions**
  - IDLE → RUN on `module_start`.
  - RUN → DRAIN once the last read pair (addr NCOEF-2/NCOEF-1) has been issued.
  - DRAIN → IDLE on handshake of the last word; `module_done` pulses in the following cycle.
- **Read pointer**: `rd_ptr`, 8 bits, cleared on start, +2 per issued read. No wrap occurs: the final issue is at NCOEF-2 (254 at the default).
- **Output buffer**: a 2-entry FIFO holds the packed words.
  - BRAM data returning at cycle t+1 is written into the FIFO at that same edge.
  - `Wm_tvalid` = FIFO not empty; `Wm_tdata` = FIFO head.
- **Read-issue rule (credit)**: a read is issued in a cycle only if all of the following hold:
  - state is RUN;
  - `occupancy + inflight − pop < 2`, where `pop = Wm_tvalid & Wm_tready`;
  - consequently the FIFO can never overflow and no BRAM data is ever lost.
- **Word counter**: `wr_cnt` counts handshakes, 0..NCOEF/2−1. The handshake at `wr_cnt == NCOEF/2−1` is the last word.
- **Stream rule**: once `Wm_tvalid` is high, `Wm_tdata` stays stable until the handshake.
- **Start while busy**: ignored; the transfer in progress is not disturbed.
- **Reset mid-operation**: returns to IDLE immediately. FIFO is cleared, in-flight reads are discarded, and no `module_done` is produced.
- **Reset values**: every output is 0; addresses are 0.

## Timing
- Start pulse in cycle 0 → RUN in cycle 1 → first read issued in cycle 1 (addr 0/1) → first `Wm_tvalid` in cycle 3.
- With `Wm_tready` held high: one word per cycle, with words in cycles 3..130 and `module_done` in cycle 131 at the default NCOEF.
- `Wm_tready` low: reads stall within 2 cycles. At most 2 words are buffered, and issue resumes in the cycle a pop occurs.
- BRAM latency is fixed at 1 cycle; no output register is inside the BRAM.

## Configuration
- `PWM_WR_TLAST_EN` defined: the `Wm_tlast` port exists and equals `Wm_tvalid & (wr_cnt == NCOEF/2−1)`.
- `PWM_WR_TLAST_EN` undefined: the port is absent and no tlast logic is built. All other behaviour is identical.

## Test plan
- **Streaming**: BRAM holds coef[i]=i; `Wm_tready`=1 and start → 128 words, word k = `{9'b0, 2k+1, 9'b0, 2k}`, first valid 3 cycles after start, `module_done` exactly at cycle 131.
- **Random backpressure**: `Wm_tready` random at 50% with coef[i]=8380416−i → all 128 words received in order, no duplicates, and `Wm_tdata` stable while valid && !ready.
- **Long stall**: hold `Wm_tready` low for 20 cycles mid-transfer → `coef_ena` idle within 2 cycles, and no word lost after release.
- **Start while busy**: `module_start` re-pulsed at word 40 → ignored; exactly one `module_done` and 128 words.
- **Reset mid-operation**: assert `rst` at word 60 → all outputs 0 and no `module_done`. A fresh start then yields a complete, correct 128-word sequence.
- **tlast**: with `PWM_WR_TLAST_EN` → `Wm_tlast` is high only on word 127 (data `{9'b0, 255, 9'b0, 254}` for coef[i]=i).
